// File: rtl/freelist_mp_pkg.sv
// Shared types and helpers for the ID free-list allocator.
package freelist_mp_pkg;

    localparam int DEF_ID_W  = 8;
    localparam int DEF_DEPTH = 256;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/freelist_mp_ram.sv
// Free-list storage: one write port, one synchronous read port.
// A same-cycle write to the read address is forwarded to the read data.
module freelist_mp_ram
    import freelist_mp_pkg::*;
#(
    parameter int ID_W  = DEF_ID_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic            clk,
    input  logic            we,
    input  logic [ID_W-1:0] waddr,
    input  logic [ID_W-1:0] wdata,
    input  logic [ID_W-1:0] raddr,
    output logic [ID_W-1:0] rdata
);

    logic [ID_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (we && waddr == raddr) rdata <= wdata;
        else rdata <= mem[raddr];
    end

endmodule

// File: rtl/freelist_mp.sv
// Circular-queue ID allocator with one grant and one return per cycle.
// FREELIST_MP_DBL_FREE_CHK_EN adds an allocated bitmap for double-free detection.
module freelist_mp
    import freelist_mp_pkg::*;
#(
    parameter int ID_W  = DEF_ID_W,
    parameter int DEPTH = DEF_DEPTH,
    localparam int CNT_W = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alloc_req,
    output logic             alloc_ack,
    output logic [ID_W-1:0]  alloc_id,
    input  logic             dealloc_req,
    input  logic [ID_W-1:0]  dealloc_id,
    output logic             dealloc_ack,
    output logic             init_done,
    output logic [CNT_W-1:0] free_cnt,
    output logic             empty,
    output logic             err_dbl_free
);

    localparam logic [ID_W-1:0]  LAST    = ID_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL    = CNT_W'(DEPTH);
    localparam logic [ID_W:0]    DEPTH_X = (ID_W + 1)'(DEPTH);

    state_t          state, state_nxt;
    logic [ID_W-1:0] init_idx, head, tail, head_nxt;
    logic [ID_W-1:0] rd_data, byp_id, grant_id;
    logic [ID_W-1:0] wr_addr, wr_data;
    logic            run, last_init, byp_vld;
    logic            grant_list, grant, dbl, dl_bad, dl_ok;
    logic            bypass, wr_en, cnt_inc;

    function automatic logic [ID_W-1:0] inc(input logic [ID_W-1:0] p);
        return (p == LAST) ? '0 : p + ID_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= INIT;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        last_init = 1'b0;
        if (state == INIT && init_idx == LAST) begin
            last_init = 1'b1;
            state_nxt = RUN;
        end
    end

    // The RAM always prefetches list[head_nxt], so rd_data is list[head].
    always_comb begin
        run        = (state == RUN);
        grant_list = run && alloc_req && !byp_vld && free_cnt != '0;
        grant      = grant_list || byp_vld;
        grant_id   = byp_vld ? byp_id : rd_data;
        dl_bad     = ({1'b0, dealloc_id} >= DEPTH_X) || (free_cnt == FULL) || dbl;
        dl_ok      = run && dealloc_req && !dl_bad;
        bypass     = dl_ok && alloc_req && free_cnt == '0 && !byp_vld;
        cnt_inc    = dl_ok && !bypass;
        wr_en      = !run || cnt_inc;
        wr_addr    = run ? tail : init_idx;
        wr_data    = run ? dealloc_id : init_idx;
        head_nxt   = grant_list ? inc(head) : head;
    end

    freelist_mp_ram #(
        .ID_W  (ID_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (head_nxt),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_ack    <= 1'b0;
            alloc_id     <= '0;
            dealloc_ack  <= 1'b0;
            err_dbl_free <= 1'b0;
            init_done    <= 1'b0;
            free_cnt     <= '0;
            init_idx     <= '0;
            head         <= '0;
            tail         <= '0;
            byp_vld      <= 1'b0;
            byp_id       <= '0;
        end else begin
            alloc_ack    <= grant;
            dealloc_ack  <= run && dealloc_req;
            err_dbl_free <= run && dealloc_req && dl_bad;
            init_done    <= init_done || last_init;
            byp_vld      <= bypass;
            head         <= head_nxt;
            if (grant) alloc_id <= grant_id;
            if (bypass) byp_id <= dealloc_id;
            if (run && cnt_inc) tail <= inc(tail);
            if (!run) init_idx <= init_idx + ID_W'(1);
            unique case (1'b1)
                last_init:               free_cnt <= FULL;
                cnt_inc && !grant_list:  free_cnt <= free_cnt + CNT_W'(1);
                grant_list && !cnt_inc:  free_cnt <= free_cnt - CNT_W'(1);
                default: ;
            endcase
        end
    end

`ifdef FREELIST_MP_DBL_FREE_CHK_EN
    logic [DEPTH-1:0] alloc_map;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_map <= '0;
        end else begin
            if (dl_ok) alloc_map[dealloc_id] <= 1'b0;
            if (grant) alloc_map[grant_id] <= 1'b1;
        end
    end

    assign dbl = !alloc_map[dealloc_id];
`else
    assign dbl = 1'b0;
`endif

    assign empty = rst_n && (free_cnt == '0);

endmodule

// File: tb/tb_freelist_mp.sv
// Randomised bench for freelist_mp against a queue-based free-list model,
// plus a directed wrap/range sequence on a DEPTH=6 instance.
module tb_freelist_mp;

    localparam int ID_W    = 8;
    localparam int DEPTH   = 256;
    localparam int CNT_W   = 9;
    localparam int S_ID_W  = 3;
    localparam int S_DEPTH = 6;
    localparam int S_CNT_W = 3;
`ifdef FREELIST_MP_DBL_FREE_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n, alloc_req, alloc_ack, dealloc_req, dealloc_ack;
    logic             init_done, empty, err_dbl_free;
    logic [ID_W-1:0]  alloc_id, dealloc_id;
    logic [CNT_W-1:0] free_cnt;

    logic               s_rst_n, s_areq, s_aack, s_dreq, s_dack;
    logic               s_init_done, s_empty, s_err;
    logic [S_ID_W-1:0]  s_aid, s_did;
    logic [S_CNT_W-1:0] s_free_cnt;

    freelist_mp #(.ID_W(ID_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alloc_req    (alloc_req),
        .alloc_ack    (alloc_ack),
        .alloc_id     (alloc_id),
        .dealloc_req  (dealloc_req),
        .dealloc_id   (dealloc_id),
        .dealloc_ack  (dealloc_ack),
        .init_done    (init_done),
        .free_cnt     (free_cnt),
        .empty        (empty),
        .err_dbl_free (err_dbl_free)
    );

    freelist_mp #(.ID_W(S_ID_W), .DEPTH(S_DEPTH)) u_small (
        .clk          (clk),
        .rst_n        (s_rst_n),
        .alloc_req    (s_areq),
        .alloc_ack    (s_aack),
        .alloc_id     (s_aid),
        .dealloc_req  (s_dreq),
        .dealloc_id   (s_did),
        .dealloc_ack  (s_dack),
        .init_done    (s_init_done),
        .free_cnt     (s_free_cnt),
        .empty        (s_empty),
        .err_dbl_free (s_err)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference model: FIFO of free IDs, outstanding set, bypass slot.
    int q[$];
    bit held[DEPTH];
    bit byp;
    int byp_id;
    int last_aid;
    bit granted;

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            q.push_back(i);
            held[i] = 1'b0;
        end
        byp = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        bit a, d, bad, e_aack, was_byp;
        int did, cnt, e_aid;
        @(posedge clk);
        a = alloc_req;
        d = dealloc_req;
        did = int'(dealloc_id);
        cnt = q.size();
        bad = 1'b0;
        e_aack = 1'b0;
        e_aid = 0;
        was_byp = byp;
        if (d) bad = (did >= DEPTH) || (cnt == DEPTH) || (CHK && !held[did]);
        if (byp) begin
            e_aack = 1'b1;
            e_aid = byp_id;
            byp = 1'b0;
        end else if (a && cnt > 0) begin
            e_aack = 1'b1;
            e_aid = q.pop_front();
        end
        if (e_aack) held[e_aid] = 1'b1;
        if (d && !bad) begin
            held[did] = 1'b0;
            if (a && cnt == 0 && !was_byp) begin
                byp = 1'b1;
                byp_id = did;
            end else begin
                q.push_back(did);
            end
        end
        granted = e_aack;
        if (e_aack) last_aid = e_aid;
        #1;
        check("alloc_ack", alloc_ack, e_aack);
        if (e_aack) check("alloc_id", alloc_id, e_aid);
        check("dealloc_ack", dealloc_ack, d);
        check("err_dbl_free", err_dbl_free, d && bad);
        check("free_cnt", free_cnt, q.size());
        check("empty", empty, q.size() == 0);
    endtask

    function automatic int pick_id();
        int st;
        if ($urandom_range(99) < 8) return int'($urandom_range(DEPTH - 1));
        st = int'($urandom_range(DEPTH - 1));
        for (int k = 0; k < DEPTH; k++)
            if (held[(st + k) % DEPTH]) return (st + k) % DEPTH;
        return int'($urandom_range(DEPTH - 1));
    endfunction

    task automatic drive(input int pa, input int pd);
        if (!(alloc_req && !alloc_ack))
            alloc_req = ($urandom_range(99) < pa);
        if (!(dealloc_req && !dealloc_ack)) begin
            dealloc_req = ($urandom_range(99) < pd);
            dealloc_id = ID_W'(pick_id());
        end
    endtask

    task automatic run_init();
        int n;
        bit saw;
        n = 0;
        saw = 1'b0;
        while (!init_done && n < 300) begin
            tick();
            n++;
            if (alloc_ack || dealloc_ack) saw = 1'b1;
        end
        check("init_latency", n, DEPTH);
        check("init_no_ack", saw, 0);
        check("init_free_cnt", free_cnt, DEPTH);
        check("init_empty", empty, 0);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_aack"}, alloc_ack, 0);
        check({tag, "_aid"}, alloc_id, 0);
        check({tag, "_dack"}, dealloc_ack, 0);
        check({tag, "_done"}, init_done, 0);
        check({tag, "_cnt"}, free_cnt, 0);
        check({tag, "_empty"}, empty, 0);
        check({tag, "_err"}, err_dbl_free, 0);
    endtask

    int s_ids[3] = '{3, 5, 1};
    int pa_tab[4] = '{95, 50, 5, 70};
    int pd_tab[4] = '{5, 50, 95, 40};

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0;
        s_rst_n = 1'b0;
        alloc_req = 1'b0;
        dealloc_req = 1'b0;
        dealloc_id = '0;
        s_areq = 1'b0;
        s_dreq = 1'b0;
        s_did = '0;
        tick();
        check_reset_outs("rst");

        // Small instance: wrap and out-of-range return.
        s_rst_n = 1'b1;
        n = 0;
        while (!s_init_done && n < 20) begin
            tick();
            n++;
        end
        check("s_init_latency", n, S_DEPTH);
        check("s_init_cnt", s_free_cnt, S_DEPTH);
        s_areq = 1'b1;
        for (int i = 0; i < S_DEPTH; i++) begin
            tick();
            check("s_aack", s_aack, 1);
            check("s_aid", s_aid, i);
        end
        s_areq = 1'b0;
        tick();
        check("s_idle_aack", s_aack, 0);
        check("s_cnt_zero", s_free_cnt, 0);
        check("s_empty", s_empty, 1);
        s_dreq = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_did = S_ID_W'(s_ids[i]);
            tick();
            check("s_dack", s_dack, 1);
            check("s_derr", s_err, 0);
        end
        s_dreq = 1'b0;
        check("s_cnt_three", s_free_cnt, 3);
        s_areq = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s_wrap_aack", s_aack, 1);
            check("s_wrap_aid", s_aid, s_ids[i]);
        end
        s_areq = 1'b0;
        check("s_cnt_after", s_free_cnt, 0);
        s_dreq = 1'b1;
        s_did = 3'd7;
        tick();
        check("s_range_dack", s_dack, 1);
        check("s_range_err", s_err, 1);
        s_dreq = 1'b0;
        tick();
        check("s_range_err_off", s_err, 0);
        check("s_range_cnt", s_free_cnt, 0);

        // Main instance: init with a pending alloc, drain, bypass.
        alloc_req = 1'b1;
        rst_n = 1'b1;
        model_reset();
        run_init();
        repeat (DEPTH + 1) step();
        dealloc_req = 1'b1;
        dealloc_id = 8'h2A;
        step();
        dealloc_req = 1'b0;
        step();
        alloc_req = 1'b0;
        step();

        for (int ph = 0; ph < 4; ph++)
            repeat (600) begin
                drive(pa_tab[ph], pd_tab[ph]);
                step();
            end
        repeat (100) begin
            drive(0, 90);
            step();
        end

        // Same ID returned twice.
        alloc_req = 1'b1;
        dealloc_req = 1'b0;
        granted = 1'b0;
        n = 0;
        while (!granted && n < 10) begin
            step();
            n++;
        end
        check("dbl_grant_seen", granted, 1);
        alloc_req = 1'b0;
        dealloc_req = 1'b1;
        dealloc_id = ID_W'(last_aid);
        step();
        step();
        dealloc_req = 1'b0;
        step();

        // Reset during back-to-back grants.
        alloc_req = 1'b1;
        repeat (5) step();
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outs("midrst");
        tick();
        check("midrst_late_ack", alloc_ack, 0);
        check("midrst_done", init_done, 0);
        rst_n = 1'b1;
        model_reset();
        run_init();
        repeat (20) step();
        alloc_req = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
